// File: rtl/uart_wb_driver.sv
// uart_wb_driver
//
// Wishbone master that drives a memory-mapped UART from the fabric side.
// Local producers push bytes into a small TX FIFO. The driver polls the UART
// status register and writes the FIFO head to the data register whenever the
// transmitter reports idle. Each bus access is a single independent cycle.
// After every access the strobe is dropped for exactly one cycle (S_REL) so
// that the slave can re-arm.
//
// Build option: define UART_DRV_RX_EN to enable the receive path. With it
// enabled, the driver also polls periodically while the FIFO is empty. On a
// rising edge of the status rx-ready flag it reads the data register and
// presents the byte on rx_data_o/rx_valid_o. Without the option the rx_*
// outputs and overrun_o are tied low, and rx_ready_i is ignored.
//
// Parameters
//   BASE_ADR  UART base; STAT at +8'h00, DATA at +8'h10
//   FIFO_AW   TX FIFO address width (depth 2**FIFO_AW)
//   TIMEOUT   cycles to wait for ack/err before abandoning an access (1..65535)
//   POLL_GAP  idle cycles between status polls while RX is enabled
//
// Ports
//   clk_i, rst_i           clock, synchronous active-low reset
//   tx_data_i/valid/ready  byte push port (push on valid && ready)
//   rx_data_o/valid/ready  received byte port (pop on valid && ready)
//   m_cyc_o..m_err_i       Wishbone master port (all outputs registered)
//   err_o                  sticky bus error / timeout flag
//   overrun_o              sticky flag: received byte overwrote an unread one

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module uart_wb_driver #(
  parameter logic [`ADR_WIDTH-1:0] BASE_ADR = '0,
  parameter int                    FIFO_AW  = 4,
  parameter int                    TIMEOUT  = 255,
  parameter int                    POLL_GAP = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [7:0]             rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [`ADR_WIDTH-1:0]  m_adr_o,
  output logic [`DAT_WIDTH-1:0]  m_dat_o,
  input  logic [`DAT_WIDTH-1:0]  m_dat_i,
  input  logic                   m_ack_i,
  input  logic                   m_err_i,
  output logic                   err_o,
  output logic                   overrun_o
);

  localparam int              AW        = `ADR_WIDTH;
  localparam int              DW        = `DAT_WIDTH;
  localparam int              DEPTH     = 1 << FIFO_AW;
  localparam logic [AW-1:0]   STAT_ADR  = BASE_ADR;
  localparam logic [AW-1:0]   DATA_ADR  = BASE_ADR + AW'(16);
  localparam logic [15:0]     TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [15:0]     POLL_W    = 16'(POLL_GAP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STAT = 3'd1,
    S_WR   = 3'd2,
    S_REL  = 3'd3
`ifdef UART_DRV_RX_EN
    ,S_RD  = 3'd4
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // TX FIFO: circular buffer with one extra pointer bit to tell full from empty
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr_reg;
  logic [FIFO_AW:0] rd_ptr_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                      (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  assign tx_ready_o = !fifo_full;
  assign push       = tx_valid_i && !fifo_full;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and registered bus outputs
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;
  state_t          ret_reg, ret_next;     // where S_REL goes afterwards
  logic            cyc_reg, cyc_next;
  logic            stb_reg, stb_next;
  logic            we_reg, we_next;
  logic [AW-1:0]   adr_reg, adr_next;
  logic [DW-1:0]   dat_reg;
  logic [15:0]     wait_reg, wait_next;
  logic            err_reg, err_next;
  logic            load_wdata;
  logic            timed_out;
  logic            bus_ok;
  logic            bus_fail;
  logic            poll_expired;

  assign timed_out = (wait_reg == TIMEOUT_W);
  // An err response wins over a simultaneous ack.
  assign bus_ok    = m_ack_i && !m_err_i;
  assign bus_fail  = m_err_i || (timed_out && !m_ack_i);

`ifdef UART_DRV_RX_EN
  logic            rx_load;
  logic            rx_rdy_q_reg, rx_rdy_q_next;
  logic [15:0]     poll_cnt_reg;

  assign poll_expired = (poll_cnt_reg == POLL_W);

  // Counts idle cycles. It restarts whenever the FSM leaves S_IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      poll_cnt_reg <= '0;
    end else if (state_reg != S_IDLE) begin
      poll_cnt_reg <= '0;
    end else if (!poll_expired) begin
      poll_cnt_reg <= poll_cnt_reg + 16'd1;
    end
  end
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ret_next   = ret_reg;
    cyc_next   = cyc_reg;
    stb_next   = stb_reg;
    we_next    = we_reg;
    adr_next   = adr_reg;
    wait_next  = wait_reg;
    err_next   = err_reg;
    load_wdata = 1'b0;
    pop        = 1'b0;
`ifdef UART_DRV_RX_EN
    rx_load       = 1'b0;
    rx_rdy_q_next = rx_rdy_q_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty || poll_expired) begin
          state_next = S_STAT;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          we_next    = 1'b0;
          adr_next   = STAT_ADR;
          wait_next  = '0;
        end
      end
      S_REL: begin
        // Strobe is low for this single cycle; launch the stored access.
        state_next = ret_reg;
        if (ret_reg == S_WR) begin
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          we_next    = 1'b1;
          adr_next   = DATA_ADR;
          wait_next  = '0;
          load_wdata = 1'b1;
        end
`ifdef UART_DRV_RX_EN
        else if (ret_reg == S_RD) begin
          cyc_next  = 1'b1;
          stb_next  = 1'b1;
          we_next   = 1'b0;
          adr_next  = DATA_ADR;
          wait_next = '0;
        end
`endif
      end
      default: begin
        // S_STAT, S_WR and S_RD: hold the strobe until the access terminates.
        if (bus_ok || bus_fail) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          state_next = S_REL;
          ret_next   = S_IDLE;
          if (bus_fail) begin
            err_next = 1'b1;
          end
          // A failed write still consumes its byte so a dead slave
          // cannot wedge the FIFO.
          if (state_reg == S_WR) begin
            pop = 1'b1;
          end
          if (bus_ok && state_reg == S_STAT) begin
`ifdef UART_DRV_RX_EN
            // The UART's ready flag stays set until the byte is read, so
            // only a rising edge starts a data read.
            rx_rdy_q_next = m_dat_i[1];
            if (m_dat_i[1] && !rx_rdy_q_reg) begin
              ret_next = S_RD;
            end else if (!fifo_empty && !m_dat_i[0]) begin
              ret_next = S_WR;
            end
`else
            if (!fifo_empty && !m_dat_i[0]) begin
              ret_next = S_WR;
            end
`endif
          end
`ifdef UART_DRV_RX_EN
          if (bus_ok && state_reg == S_RD) begin
            rx_load = 1'b1;
          end
`endif
        end else begin
          wait_next = wait_reg + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      ret_reg   <= S_IDLE;
      cyc_reg   <= 1'b0;
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      wait_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
      cyc_reg   <= cyc_next;
      stb_reg   <= stb_next;
      we_reg    <= we_next;
      adr_reg   <= adr_next;
      wait_reg  <= wait_next;
      err_reg   <= err_next;
      // The FIFO head is stable here: nothing pops outside S_WR.
      if (load_wdata) begin
        dat_reg <= DW'(fifo_mem[rd_ptr_reg[FIFO_AW-1:0]]);
      end
    end
  end

  assign m_cyc_o = cyc_reg;
  assign m_stb_o = stb_reg;
  assign m_we_o  = we_reg;
  assign m_adr_o = adr_reg;
  assign m_dat_o = dat_reg;
  assign err_o   = err_reg;

  // ---------------------------------------------------------------------------
  // Receive holding register
  // ---------------------------------------------------------------------------
`ifdef UART_DRV_RX_EN
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       overrun_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      rx_rdy_q_reg <= 1'b0;
    end else begin
      rx_rdy_q_reg <= rx_rdy_q_next;
      if (rx_load) begin
        rx_data_reg  <= m_dat_i[7:0];
        rx_valid_reg <= 1'b1;
        // Only an overrun if the previous byte is not being taken this cycle.
        if (rx_valid_reg && !rx_ready_i) begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready_i) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;
  assign overrun_o  = overrun_reg;
`else
  assign rx_data_o  = '0;
  assign rx_valid_o = 1'b0;
  assign overrun_o  = 1'b0;
`endif

  // Inputs and configuration that some builds do not consume.
  logic unused_sink;
  assign unused_sink = ^{m_dat_i, rx_ready_i, POLL_W};

endmodule

// File: tb/tb_uart_wb_driver.sv
`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module tb_uart_wb_driver;

  localparam int            AW      = `ADR_WIDTH;
  localparam int            DW      = `DAT_WIDTH;
  localparam int            TIMEOUT = 255;
  localparam logic [AW-1:0] BASE    = AW'(32'h0000_0100);
  localparam logic [AW-1:0] STAT_A  = BASE;
  localparam logic [AW-1:0] DATA_A  = BASE + AW'(16);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [7:0]    tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [AW-1:0] m_adr_o;
  logic [DW-1:0] m_dat_o;
  logic [DW-1:0] m_dat_i;
  logic          m_ack_i, m_err_i;
  logic          err_o, overrun_o;

  uart_wb_driver #(
    .BASE_ADR (BASE),
    .FIFO_AW  (4),
    .TIMEOUT  (TIMEOUT),
    .POLL_GAP (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .m_cyc_o    (m_cyc_o),
    .m_stb_o    (m_stb_o),
    .m_we_o     (m_we_o),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_ack_i    (m_ack_i),
    .m_err_i    (m_err_i),
    .err_o      (err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes still owed to the bus, in push order.
  logic [7:0] exp_q[$];
  logic [7:0] rx_exp_q[$];
  bit         stat_rx_q[$];
  int         exp_writes = 0;

  // Slave behaviour knobs.
  bit         wr_respond = 1'b1;
  bit         wr_err     = 1'b0;
  int         busy_until = 0;
  int         busy_pct   = 0;
  int         max_lat    = 0;

  // Observation counters.
  int         stat_cnt  = 0;
  int         wr_starts = 0;
  int         rd_starts = 0;
  logic [7:0] rx_last   = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Wishbone slave: registered ack after a random latency
  // ---------------------------------------------------------------------------
  logic          ack_r = 1'b0, err_r = 1'b0;
  logic [DW-1:0] rdat_r = '0;
  int            lat_cnt = 0, lat_target = 0;
  logic          busy_b, rxf_b;
  logic [7:0]    rbyte;
  logic [DW-1:0] rtmp;

  assign m_ack_i = ack_r;
  assign m_err_i = err_r;
  assign m_dat_i = rdat_r;

  always @(posedge clk_i) begin
    ack_r <= 1'b0;
    err_r <= 1'b0;
    if (m_cyc_o && m_stb_o && !ack_r && !err_r) begin
      if (lat_cnt < lat_target) begin
        lat_cnt++;
      end else if (m_we_o) begin
        if (wr_err || wr_respond) begin
          if (wr_err) err_r <= 1'b1;
          else        ack_r <= 1'b1;
          lat_cnt    = 0;
          lat_target = $urandom_range(0, max_lat);
        end
      end else begin
        ack_r <= 1'b1;
        rtmp = DW'({$urandom(), $urandom()});
        if (m_adr_o == STAT_A) begin
          busy_b = (stat_cnt < busy_until) || ($urandom_range(0, 99) < busy_pct);
          rxf_b  = 1'b0;
          if (stat_rx_q.size() > 0) rxf_b = stat_rx_q.pop_front();
          rtmp[1:0] = {rxf_b, busy_b};
          stat_cnt++;
        end else begin
          rbyte = 8'($urandom_range(0, 255));
          rx_exp_q.push_back(rbyte);
          rx_last   = rbyte;
          rtmp[7:0] = rbyte;
        end
        rdat_r <= rtmp;
        lat_cnt    = 0;
        lat_target = $urandom_range(0, max_lat);
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: every write attempt must carry the oldest outstanding byte
  // ---------------------------------------------------------------------------
  bit prev_wr = 1'b0, prev_rd = 1'b0;
  logic [7:0] mon_exp;

  always begin
    @(posedge clk_i);
    #1;
    if (m_stb_o && m_we_o && !prev_wr) begin
      wr_starts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual=%0h required=none", m_dat_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_data", m_dat_o, 64'(mon_exp));
        check("wr_adr", m_adr_o, DATA_A);
      end
    end
    if (m_stb_o && !m_we_o && !prev_rd && m_adr_o == DATA_A) rd_starts++;
    prev_wr = m_stb_o && m_we_o;
    prev_rd = m_stb_o && !m_we_o && (m_adr_o == DATA_A);
`ifdef UART_DRV_RX_EN
    if (rx_valid_o && rx_ready_i) begin
      if (rx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_data_o);
      end else begin
        check("rx_data", rx_data_o, 64'(rx_exp_q.pop_front()));
      end
    end
`else
    check("rx_off", {rx_valid_o, rx_data_o, overrun_o}, 0);
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_byte(input logic [7:0] b);
    int g = 0;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && g < 3000) begin
      tick;
      g++;
    end
    if (g >= 3000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=ready0 required=ready1");
    end else begin
      exp_q.push_back(b);
      exp_writes++;
    end
    tick;
    tx_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((exp_q.size() != 0 || m_cyc_o) && g < 3000) begin
      tick;
      g++;
    end
    repeat (20) tick;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int g;
    int base;
    int cnt;
    rst_i      = 1'b0;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b1;
    repeat (3) tick;

    check("rst_cyc", m_cyc_o, 0);
    check("rst_stb", m_stb_o, 0);
    check("rst_we", m_we_o, 0);
    check("rst_adr", m_adr_o, 0);
    check("rst_dat", m_dat_o, 0);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_err", err_o, 0);
    check("rst_overrun", overrun_o, 0);

    rst_i = 1'b1;
    repeat (3) tick;

    // Single byte, UART idle, one-cycle ack: exact bus timeline.
`ifndef UART_DRV_RX_EN
    push_byte(8'h41);                       // now in cycle 1
    check("c1_stb", m_stb_o, 0);
    tick;                                   // cycle 2
    check("c2_stat_stb", m_stb_o, 1);
    check("c2_stat_we", m_we_o, 0);
    check("c2_stat_adr", m_adr_o, STAT_A);
    tick; tick;                             // cycle 4
    check("c4_rel_stb", m_stb_o, 0);
    tick;                                   // cycle 5
    check("c5_wr_stb", m_stb_o, 1);
    check("c5_wr_we", m_we_o, 1);
    tick; tick;                             // cycle 7
    check("c7_rel_stb", m_stb_o, 0);
    repeat (3) tick;                        // cycle 10
    check("c10_no_repoll", m_cyc_o, 0);
    drain("drain_single");
`endif

    // Fill the FIFO while the transmitter reports busy for three polls.
    busy_until = stat_cnt + 3;
    base = wr_starts;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
`ifndef UART_DRV_RX_EN
    check("full_ready_low", tx_ready_o, 0);
`endif
    tx_data_i  = 8'hEE;
    tx_valid_i = 1'b1;
    tick;
    tx_valid_i = 1'b0;
    g = 0;
    while (wr_starts == base && g < 500) begin
      tick;
      g++;
    end
    check("polls_before_write", stat_cnt - busy_until, 1);
    drain("drain_burst");
    check("ready_after_drain", tx_ready_o, 1);

    // Bus error on a data write: byte consumed, next byte proceeds.
    wr_err = 1'b1;
    push_byte(8'hA5);
    push_byte(8'h5A);
    g = 0;
    while (!err_o && g < 400) begin
      tick;
      g++;
    end
    wr_err = 1'b0;
    check("err_on_bus_err", err_o, 1);
    drain("drain_err");

    // Reset in the middle of a write.
    push_byte(8'hC0);
    push_byte(8'hC1);
    push_byte(8'hC2);
    g = 0;
    while (!(m_stb_o && m_we_o) && g < 400) begin
      tick;
      g++;
    end
    #1;
    exp_writes -= exp_q.size();
    exp_q.delete();
    rst_i = 1'b0;
    tick;
    check("rstmid_stb", m_stb_o, 0);
    check("rstmid_cyc", m_cyc_o, 0);
    check("rstmid_err", err_o, 0);
    check("rstmid_ready", tx_ready_o, 1);
    rst_i = 1'b1;
    base = wr_starts;
    repeat (40) tick;
    check("rstmid_fifo_flushed", wr_starts - base, 0);

    // Slave ignores data writes: timeout, byte dropped, next byte goes out.
    wr_respond = 1'b0;
    push_byte(8'h77);
    push_byte(8'h88);
    g = 0;
    while (!(m_stb_o && m_we_o) && g < 400) begin
      tick;
      g++;
    end
    cnt = 0;
    while (m_stb_o && m_we_o && cnt < 1000) begin
      cnt++;
      tick;
    end
    wr_respond = 1'b1;
    check("timeout_stb_cycles", cnt, TIMEOUT + 1);
    check("timeout_err", err_o, 1);
    drain("drain_timeout");

`ifdef UART_DRV_RX_EN
    // Status rx flag 0,1,1,0,1: two rising edges, two data reads.
    base = rd_starts;
    rx_exp_q.delete();
    stat_rx_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    g = 0;
    while (stat_rx_q.size() != 0 && g < 1000) begin
      tick;
      g++;
    end
    repeat (40) tick;
    check("rx_read_count", rd_starts - base, 2);
    check("rx_no_overrun", overrun_o, 0);
    // Same with the consumer stalled: the second read overruns.
    rx_ready_i = 1'b0;
    stat_rx_q = '{1'b1, 1'b0, 1'b1};
    g = 0;
    while (stat_rx_q.size() != 0 && g < 1000) begin
      tick;
      g++;
    end
    repeat (40) tick;
    check("rx_overrun_set", overrun_o, 1);
    check("rx_overwritten", rx_data_o, 64'(rx_last));
    void'(rx_exp_q.pop_front());
    rx_ready_i = 1'b1;
    repeat (5) tick;
    check("rx_all_consumed", rx_exp_q.size(), 0);
`endif

    // Randomized traffic with busy polls and variable ack latency.
    max_lat  = 3;
    busy_pct = 30;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) tick;
    end
    drain("drain_random");
    busy_pct = 0;
    check("write_count", wr_starts, exp_writes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
